servant_q_uart_rx: RTL

//  Downstream consumer of the servant SoC's q output when firmware bit-bangs
//  8N1 UART on it. Samples q, decodes frames and buffers bytes in a FIFO for a

---
 rtl/servant_q_uart_rx_pkg.sv | 19 +
 rtl/servant_sync_fifo.sv | 68 ++++++
 rtl/servant_q_uart_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/servant_q_uart_rx_pkg.sv
// Shared definitions for the servant q-line UART receiver (and the future TX).
package servant_q_uart_rx_pkg;

    // Data bits per 8N1 frame.
    localparam int UART_BITS   = 8;

    // Depth of the input synchronizer chain on the asynchronous q line.
    localparam int SYNC_STAGES = 2;

    // Receiver frame-decoding states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/servant_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered occupancy.
// A pop on an empty FIFO is ignored; a push on a full FIFO only succeeds when
// a pop retires the head in the same cycle.
module servant_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;

    // Head is driven straight from the array; forced to zero while empty so
    // the output is defined from reset onward.
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage array, no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at their power-of-two width; occupancy tracks
    // the net effect of push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/servant_q_uart_rx.sv
// 8N1 UART receiver for the servant SoC q output. Synchronizes the line,
// decodes frames with a mid-bit sampling baud counter and buffers received
// bytes in a FWFT FIFO for a downstream reader.
module servant_q_uart_rx
    import servant_q_uart_rx_pkg::*;
#(
    parameter int BAUD_DIV   = 277,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            wb_clk,
    input  logic                            wb_rst,
    input  logic                            i_q,
    output logic [7:0]                      o_data,
    output logic                            o_vld,
    input  logic                            i_rdy,
    output logic                            o_frame_err,
    output logic                            o_overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(UART_BITS);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_q;
    logic                   s_q_prev_reg;

    rx_state_t              state_reg,     state_next;
    logic [CNT_W-1:0]       cnt_reg,       cnt_next;
    logic [IDX_W-1:0]       bit_idx_reg,   bit_idx_next;
    logic [UART_BITS-1:0]   shift_reg,     shift_next;
    logic                   push_reg,      push_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   overflow_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop_ok;
    logic [OCC_W-1:0]       fifo_count;

    // Synchronizer chain: stage 0 takes the raw line, each later stage the
    // previous one.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = i_q;
            end else begin : g_chain
                assign sync_d[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign s_q = sync_reg[SYNC_STAGES-1];

    // Synchronizer flops reset to the idle (high) line level.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            sync_reg     <= '1;
            s_q_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= sync_d;
            s_q_prev_reg <= s_q;
        end
    end

    // Frame decoder state, baud counter, shift register and output pulses.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            push_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            push_reg      <= push_next;
            frame_err_reg <= frame_err_next;
            overflow_reg  <= push_reg && fifo_full && !pop_ok;
        end
    end

    // Next-state logic: a counter value of zero marks a bit sample point.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        push_next      = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (s_q_prev_reg && !s_q) begin
                    cnt_next   = HALF_LOAD;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == '0) begin
                    if (!s_q) begin
                        cnt_next     = FULL_LOAD;
                        bit_idx_next = '0;
                        state_next   = ST_DATA;
                    end else begin
                        // Start bit did not hold until mid-bit: a glitch.
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == '0) begin
                    shift_next = {s_q, shift_reg[UART_BITS-1:1]};
                    cnt_next   = FULL_LOAD;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_reg == '0) begin
                    if (s_q) begin
                        push_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_BREAK: begin
                // Stay here while the line is held low so a break yields a
                // single error pulse.
                if (s_q) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pop_ok = i_rdy && !fifo_empty;

    servant_sync_fifo #(
        .WIDTH (UART_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk),
        .rst       (wb_rst),
        .push      (push_reg),
        .push_data (shift_reg),
        .pop       (i_rdy),
        .pop_data  (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_vld       = !fifo_empty;
    assign o_count     = fifo_count;
    assign o_frame_err = frame_err_reg;
    assign o_overflow  = overflow_reg;

endmodule
